// File: rtl/ecp3_clk_align.sv
// ecp3_clk_align: sequences PLL lock wait, ECLKSYNC stop, divider reset release
// and clock restart, then qualifies the DDR phase-detector status. A failed
// check retries the whole stop/reset/restart loop up to MAX_TRIES times.
module ecp3_clk_align #(
  parameter int unsigned LOCK_WAIT   = 64,
  parameter int unsigned STOP_CYCLES = 4,
  parameter int unsigned RST_CYCLES  = 4,
  parameter int unsigned SETTLE      = 8,
  parameter int unsigned MATCH_COUNT = 4,
  parameter int unsigned MAX_TRIES   = 16,
  parameter logic [1:0]  TARGET      = 2'b01
) (
  input  logic                               sclk,
  input  logic                               reset,
  input  logic                               pll_lock,
  input  logic [1:0]                         align_status,
  input  logic                               realign,
  output logic                               eclk_stop,
  output logic                               ddr_rst,
  output logic                               ready,
  output logic                               fail,
  output logic [$clog2(MAX_TRIES+1)-1:0]     tries
);

  localparam int unsigned TRIES_W = $clog2(MAX_TRIES + 1);
  localparam int unsigned MAX_AB  = (LOCK_WAIT > STOP_CYCLES) ? LOCK_WAIT : STOP_CYCLES;
  localparam int unsigned MAX_CD  = (RST_CYCLES > SETTLE) ? RST_CYCLES : SETTLE;
  localparam int unsigned MAX_ABC = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
  localparam int unsigned MAX_T   = (MAX_ABC > MATCH_COUNT) ? MAX_ABC : MATCH_COUNT;
  localparam int unsigned CNT_W   = (MAX_T > 1) ? $clog2(MAX_T) : 1;

  typedef enum logic [3:0] {
    S_IDLE,
    S_LOCKWAIT,
    S_STOP,
    S_RELEASE,
    S_RUN,
    S_CHECK,
    S_RESYNC,
    S_DONE,
    S_FAIL
  } state_e;

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [TRIES_W-1:0]   tries_q, tries_d;
  logic                 lock_meta_q, lock_s_q;
  logic                 eclk_stop_q, eclk_stop_d;
  logic                 ddr_rst_q, ddr_rst_d;
  logic                 ready_q, ready_d;
  logic                 fail_q, fail_d;

  // Terminal count for the shared down-counter on entry to a timed state.
  function automatic logic [CNT_W-1:0] reload(input state_e s);
    reload = '0;
    case (s)
      S_LOCKWAIT: reload = CNT_W'(LOCK_WAIT - 1);
      S_STOP:     reload = CNT_W'(STOP_CYCLES - 1);
      S_RELEASE:  reload = CNT_W'(RST_CYCLES - 1);
      S_RUN:      reload = CNT_W'(SETTLE - 1);
      S_CHECK:    reload = CNT_W'(MATCH_COUNT - 1);
      S_RESYNC:   reload = CNT_W'(RST_CYCLES - 1);
      default:    reload = '0;
    endcase
  endfunction

  // Two-flop synchroniser for the asynchronous PLL lock.
  always_ff @(posedge sclk) begin
    if (reset) begin
      lock_meta_q <= 1'b0;
      lock_s_q    <= 1'b0;
    end else begin
      lock_meta_q <= pll_lock;
      lock_s_q    <= lock_meta_q;
    end
  end

  // State, timer, retry count and registered outputs.
  always_ff @(posedge sclk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      tries_q     <= '0;
      eclk_stop_q <= 1'b0;
      ddr_rst_q   <= 1'b1;
      ready_q     <= 1'b0;
      fail_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      tries_q     <= tries_d;
      eclk_stop_q <= eclk_stop_d;
      ddr_rst_q   <= ddr_rst_d;
      ready_q     <= ready_d;
      fail_q      <= fail_d;
    end
  end

  // Next-state, timer and retry logic; outputs decoded from the next state.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    tries_d     = tries_q;
    eclk_stop_d = 1'b0;
    ddr_rst_d   = 1'b1;
    ready_d     = 1'b0;
    fail_d      = 1'b0;

    if (!lock_s_q && (state_q != S_IDLE)) begin
      // Lock loss beats realign and timer expiry; tries survives until restart.
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (lock_s_q) begin
            state_d = S_LOCKWAIT;
            tries_d = '0;
          end
        end
        S_LOCKWAIT: if (cnt_q == '0) state_d = S_STOP;
        S_STOP:     if (cnt_q == '0) state_d = S_RELEASE;
        S_RELEASE:  if (cnt_q == '0) state_d = S_RUN;
        S_RUN:      if (cnt_q == '0) state_d = S_CHECK;
        S_CHECK: begin
          if (align_status != TARGET) begin
            if (tries_q >= TRIES_W'(MAX_TRIES - 1)) begin
              state_d = S_FAIL;
              tries_d = TRIES_W'(MAX_TRIES);
            end else begin
              state_d = S_RESYNC;
              tries_d = tries_q + TRIES_W'(1);
            end
          end else if (cnt_q == '0) begin
            state_d = S_DONE;
          end
        end
        S_RESYNC:   if (cnt_q == '0) state_d = S_STOP;
        S_DONE, S_FAIL: begin
          if (realign) begin
            state_d = S_RESYNC;
            tries_d = '0;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

    // Shared timer: reload on every state change, otherwise count down to zero.
    if (state_d != state_q) begin
      cnt_d = reload(state_d);
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
    end

    case (state_d)
      S_STOP:    begin eclk_stop_d = 1'b1; ddr_rst_d = 1'b1; end
      S_RELEASE: begin eclk_stop_d = 1'b1; ddr_rst_d = 1'b0; end
      S_RUN:     ddr_rst_d = 1'b0;
      S_CHECK:   ddr_rst_d = 1'b0;
      S_DONE:    begin ddr_rst_d = 1'b0; ready_d = 1'b1; end
      S_FAIL:    fail_d = 1'b1;
      default:   ddr_rst_d = 1'b1;
    endcase
  end

  assign eclk_stop = eclk_stop_q;
  assign ddr_rst   = ddr_rst_q;
  assign ready     = ready_q;
  assign fail      = fail_q;
  assign tries     = tries_q;

endmodule

// File: tb/tb_ecp3_clk_align.sv
// Directed bench for ecp3_clk_align: table of retry scenarios plus hand-written
// sequences for glitch, lock loss, reset and ignored realign.
module tb_ecp3_clk_align;

  localparam int unsigned TW = 5;
  localparam logic [1:0]  TGT = 2'b01;

  logic          sclk = 1'b0;
  logic          reset;
  logic          pll_lock;
  logic          realign;
  logic [1:0]    align_status;
  logic          eclk_stop, ddr_rst, ready, fail;
  logic [TW-1:0] tries;

  int n_tests = 0;
  int n_fail  = 0;
  int edge_n;
  int stop_cyc, stop_rel_cyc, excl_viol;
  int hit;

  typedef struct {
    int         bad;
    logic [1:0] bad_val;
    int         exp_edge;
    int         exp_tries;
    bit         exp_fail;
  } vec_t;

  vec_t vecs[5];

  always #5 sclk = ~sclk;

  ecp3_clk_align dut (
    .sclk         (sclk),
    .reset        (reset),
    .pll_lock     (pll_lock),
    .align_status (align_status),
    .realign      (realign),
    .eclk_stop    (eclk_stop),
    .ddr_rst      (ddr_rst),
    .ready        (ready),
    .fail         (fail),
    .tries        (tries)
  );

  task automatic tick();
    @(posedge sclk);
    #1;
    edge_n++;
    if (eclk_stop === 1'b1) stop_cyc++;
    if (eclk_stop === 1'b1 && ddr_rst === 1'b0) stop_rel_cyc++;
    if (ready === 1'b1 && fail === 1'b1) excl_viol++;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic do_reset();
    reset        = 1'b1;
    pll_lock     = 1'b0;
    realign      = 1'b0;
    align_status = TGT;
    ticks(3);
    reset = 1'b0;
    stop_cyc     = 0;
    stop_rel_cyc = 0;
    edge_n       = 0;
  endtask

  // Runs until ready or fail; the first `bad` CHECK windows see bad_val.
  task automatic run_seq(input int bad, input logic [1:0] bv, output int h);
    int   falls;
    logic prev;
    falls = 0;
    prev  = eclk_stop;
    h     = -1;
    for (int k = 0; k < 1000; k++) begin
      tick();
      if (prev === 1'b1 && eclk_stop === 1'b0) begin
        falls++;
        align_status = (falls > bad) ? TGT : bv;
      end
      prev = eclk_stop;
      if (ready === 1'b1 || fail === 1'b1) begin
        h = edge_n;
        break;
      end
    end
  endtask

  initial begin
    vecs[0] = '{bad: 0,  bad_val: 2'b00, exp_edge: 87,  exp_tries: 0,  exp_fail: 1'b0};
    vecs[1] = '{bad: 1,  bad_val: 2'b10, exp_edge: 108, exp_tries: 1,  exp_fail: 1'b0};
    vecs[2] = '{bad: 2,  bad_val: 2'b00, exp_edge: 129, exp_tries: 2,  exp_fail: 1'b0};
    vecs[3] = '{bad: 15, bad_val: 2'b11, exp_edge: 402, exp_tries: 15, exp_fail: 1'b0};
    vecs[4] = '{bad: 99, bad_val: 2'b11, exp_edge: 399, exp_tries: 16, exp_fail: 1'b1};
    excl_viol = 0;

    // Reset values
    do_reset();
    check("rst_eclk_stop", 32'(eclk_stop), 0);
    check("rst_ddr_rst",   32'(ddr_rst),   1);
    check("rst_ready",     32'(ready),     0);
    check("rst_fail",      32'(fail),      0);
    check("rst_tries",     32'(tries),     0);

    // Table of retry scenarios
    for (int i = 0; i < 5; i++) begin
      int loops;
      loops = vecs[i].exp_fail ? 16 : vecs[i].bad + 1;
      do_reset();
      pll_lock = 1'b1;
      run_seq(vecs[i].bad, vecs[i].bad_val, hit);
      check($sformatf("v%0d_edge", i),   32'(hit),   32'(vecs[i].exp_edge));
      check($sformatf("v%0d_tries", i),  32'(tries), 32'(vecs[i].exp_tries));
      check($sformatf("v%0d_ready", i),  32'(ready), 32'(!vecs[i].exp_fail));
      check($sformatf("v%0d_fail", i),   32'(fail),  32'(vecs[i].exp_fail));
      check($sformatf("v%0d_ddr_rst", i), 32'(ddr_rst), 32'(vecs[i].exp_fail));
      check($sformatf("v%0d_stop_cyc", i), 32'(stop_cyc), 32'(loops * 8));
      check($sformatf("v%0d_stop_rel", i), 32'(stop_rel_cyc), 32'(loops * 4));
      if (vecs[i].exp_fail) begin
        // realign out of FAIL restarts at RESYNC
        align_status = TGT;
        realign = 1'b1;
        tick();
        realign = 1'b0;
        edge_n  = 0;
        check("rl_fail_clr",  32'(fail),      0);
        check("rl_tries_clr", 32'(tries),     0);
        check("rl_ddr_rst",   32'(ddr_rst),   1);
        check("rl_eclk_stop", 32'(eclk_stop), 0);
        ticks(3);
        check("rl_resync_len", 32'(eclk_stop), 0);
        tick();
        check("rl_stop_start", 32'(eclk_stop), 1);
        run_seq(0, TGT, hit);
        check("rl_ready_edge", 32'(hit),   24);
        check("rl_ready_tries", 32'(tries), 0);
      end
    end

    // Glitch in CHECK: 01,01,00,01
    do_reset();
    pll_lock = 1'b1;
    ticks(85);
    align_status = 2'b00;
    tick();
    align_status = TGT;
    check("gl_tries",  32'(tries), 1);
    check("gl_ready0", 32'(ready), 0);
    tick();
    check("gl_ready1", 32'(ready), 0);
    run_seq(0, TGT, hit);
    check("gl_ready_edge", 32'(hit),   110);
    check("gl_tries_end",  32'(tries), 1);

    // Lock loss during RELEASE
    do_reset();
    pll_lock = 1'b1;
    ticks(72);
    pll_lock = 1'b0;
    ticks(2);
    check("llr_still_stop", 32'(eclk_stop), 1);
    check("llr_still_rel",  32'(ddr_rst),   0);
    tick();
    check("llr_eclk_stop", 32'(eclk_stop), 0);
    check("llr_ddr_rst",   32'(ddr_rst),   1);
    check("llr_ready",     32'(ready),     0);
    ticks(3);
    pll_lock = 1'b1;
    edge_n = 0;
    run_seq(0, TGT, hit);
    check("llr_rerun_edge", 32'(hit), 87);

    // Lock loss during DONE, tries retained until restart
    do_reset();
    pll_lock = 1'b1;
    run_seq(1, 2'b00, hit);
    check("lld_first_edge", 32'(hit), 108);
    pll_lock = 1'b0;
    ticks(2);
    check("lld_ready_hold", 32'(ready), 1);
    tick();
    check("lld_ready",   32'(ready),     0);
    check("lld_ddr_rst", 32'(ddr_rst),   1);
    check("lld_eclk",    32'(eclk_stop), 0);
    check("lld_tries",   32'(tries),     1);
    pll_lock = 1'b1;
    edge_n = 0;
    run_seq(0, TGT, hit);
    check("lld_rerun_edge",  32'(hit),   87);
    check("lld_rerun_tries", 32'(tries), 0);

    // Synchronous reset in STOP
    do_reset();
    pll_lock = 1'b1;
    ticks(68);
    check("rs_in_stop", 32'(eclk_stop), 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rs_eclk_stop", 32'(eclk_stop), 0);
    check("rs_ddr_rst",   32'(ddr_rst),   1);
    check("rs_ready",     32'(ready),     0);
    check("rs_fail",      32'(fail),      0);
    edge_n = 0;
    run_seq(0, TGT, hit);
    check("rs_rerun_edge", 32'(hit), 87);

    // realign during RUN is ignored
    do_reset();
    pll_lock = 1'b1;
    ticks(77);
    realign = 1'b1;
    tick();
    realign = 1'b0;
    run_seq(0, TGT, hit);
    check("ign_ready_edge", 32'(hit),   87);
    check("ign_tries",      32'(tries), 0);

    check("ready_fail_excl", 32'(excl_viol), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
